sync_queue: RTL

SYNC_QUEUE -- requirements
Module: sync_queue

---
 rtl/queue_pkg.sv | 10 +
 rtl/ram_array.sv | 25 ++
 rtl/sync_queue.sv | 103 ++++++++++
 3 files changed

// File: rtl/queue_pkg.sv
// Shared sizing defaults for the synchronous queue and its storage array.
// Queue depth is derived from the address width.
package queue_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction
endpackage

// File: rtl/ram_array.sv
// Simple dual-port storage: synchronous write, registered synchronous read.
// On a same-address read and write, the read returns the old word.
module ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (i_wen) r_mem[i_waddr] <= i_wdata;
    // Read register holds between reads so it doubles as the output word.
    if (i_ren) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/sync_queue.sv
// Single-clock queue: pointer/count control around a ram_array, with a
// one-cycle registered read and a tri-stated output driver.
module sync_queue
  import queue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              OutEn_i,
  output wire  [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o,
  output logic              underflow_o
);
  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_cnt;
  logic              r_full;
  logic              r_empty;
  logic              r_valid;
  logic              r_ovf;
  logic              r_udf;
  logic              r_out_zero;

  logic              w_pop_acc;
  logic              w_push_acc;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_data;

  // Full queue still takes a push when a pop frees a slot in the same cycle.
  assign w_pop_acc  = pop_i & ~r_empty;
  assign w_push_acc = push_i & (~r_full | w_pop_acc);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push_acc && !w_pop_acc)
      w_cnt_nxt = r_cnt + CNT_ONE;
    else if (!w_push_acc && w_pop_acc)
      w_cnt_nxt = r_cnt - CNT_ONE;
  end

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .i_wen   (w_push_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_i),
    .i_ren   (w_pop_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_out_zero <= 1'b1;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CNT_FULL);
      r_empty <= (w_cnt_nxt == '0);
      r_valid <= w_pop_acc;
      r_ovf   <= push_i & ~w_push_acc;
      r_udf   <= pop_i & ~w_pop_acc;
      if (w_pop_acc) r_out_zero <= 1'b0;
    end
  end

  // The array has no reset, so the output reads zero until the first pop.
  assign w_data = r_out_zero ? '0 : w_rdata;
  assign data_o = OutEn_i ? w_data : {DATA_W{1'bz}};

  assign valid_o     = r_valid;
  assign full_o      = r_full;
  assign empty_o     = r_empty;
  assign count_o     = r_cnt;
  assign overflow_o  = r_ovf;
  assign underflow_o = r_udf;
endmodule
